seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receiving end of the 7-segment display interface: samples a multiplexed, active-low segment bus plus active-low digit selects.
- Debounces each sample run, reverse-maps segment patterns to 4-bit hex values and stores one nibble per digit.
- Used for loopback self-check of the display path and for reading external 7-segment panels into the accelerometer control logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits captured.
- STABLE_CYCLES, 8, consecutive identical qualified samples required before commit (≥2).
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  sample strobe; inputs are evaluated only in cycles where it is high.
- seg_in  in  [0:6]  active-low segments; seg_in[0]=a … seg_in[6]=g.
- dig_sel  in  NUM_DIGITS  active-low one-hot digit select; bit i low selects digit i.
- digits_out  out  4*NUM_DIGITS  captured nibbles; digit i occupies [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i set when digit i committed in the current frame.
- frame_done  out  1  one-cycle pulse when all digits are committed.
- err_pattern  out  1  sticky flag: bad pattern or bad select committed; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, stability counter 0, sample register 0, state IDLE.
- Decode table, seg_in[0:6], maps to hex value:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 0000100→9, 0001000→A, 1100000→b, 0110001→C
  - 1000010→d, 0110000→E, 0111000→F
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8
  - Any other pattern is a miss.
- Sample handling (state TRACK; entered from IDLE on the first sample_en):
  - If {dig_sel, seg_in} equals the stored sample, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise the new sample is stored and cnt=1.
  - If sample_en is low, all state holds.
- Commit (state COMMIT, one cycle) occurs on the sample where cnt reaches STABLE_CYCLES. Exactly one commit per stable run; further identical samples do not recommit.
- Commit actions:
  - dig_sel all ones (blank): no write, no error.
  - Exactly one bit i low and table hit: write the nibble to digit i, set digit_valid[i].
  - More than one bit low, or table miss: set err_pattern, no write.
- Latency: digits_out and digit_valid update 1 cycle after the qualifying sample_en edge.
- After COMMIT the FSM returns to TRACK.
- Frame completion: when a commit makes digit_valid all-ones, frame_done pulses on the next cycle and digit_valid clears in that same cycle. digits_out retains its values.
- Recommitting an already-valid digit overwrites the nibble; digit_valid stays set.
- A sample change during COMMIT is handled in the next TRACK cycle; no samples are lost, because COMMIT also performs the compare/store.
- rst mid-run aborts any partial run and clears all state regardless of FSM state.

Optional Feature:
- Macro: SEG7_CAP_DP_EN.
- Defined:
  - Adds input dp_in (1, active low) and output dp_out (NUM_DIGITS).
  - dp_in joins the stability compare.
  - On a valid commit, dp_out[i] = ~dp_in.
  - dp_out resets to 0.
- Undefined: both ports are absent and behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg:
  - SEG_W=7.
  - The 16 pattern constants SEG7_HEX_0..SEG7_HEX_F.
  - FSM state enum {IDLE, TRACK, COMMIT}.
- Sub-module seg7_pattern_lookup: combinational; seg pattern in → {hit, nibble} out. It is the inverse of the existing encoding table.

Test Plan:
- rst=1 for 2 cycles, then release → all outputs 0; err_pattern=0.
- dig_sel=4'b1110, seg_in=0010010 held for 8 sample_en pulses → digits_out[3:0]=2, digit_valid=0001 one cycle after the 8th sample; a 9th identical sample causes no second commit.
- Same pattern for 7 samples, then seg_in=0000110 for 8 samples → digit 0 = 3; value 2 is never written.
- Cycle digits 0..3 with 1, b, C, F, 8 samples each → frame_done pulses once, digit_valid returns to 0000, digits_out=16'hFCB1.
- seg_in=1111110 (miss), or dig_sel=4'b1100 with a valid pattern, for 8 samples → err_pattern=1 and stays 1; digits_out unchanged.
- rst asserted after 5 of 8 stable samples, then 3 more samples → no commit; a fresh full run of 8 samples is required.

Source files
------------

// File: rtl/seg7_pkg.sv
// Segment patterns (index 0 = segment a, active low) and capture FSM states shared by the 7-segment capture block.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [0:SEG_W-1] SEG7_HEX_0 = 7'b0000001;
  localparam logic [0:SEG_W-1] SEG7_HEX_1 = 7'b1001111;
  localparam logic [0:SEG_W-1] SEG7_HEX_2 = 7'b0010010;
  localparam logic [0:SEG_W-1] SEG7_HEX_3 = 7'b0000110;
  localparam logic [0:SEG_W-1] SEG7_HEX_4 = 7'b1001100;
  localparam logic [0:SEG_W-1] SEG7_HEX_5 = 7'b0100100;
  localparam logic [0:SEG_W-1] SEG7_HEX_6 = 7'b0100000;
  localparam logic [0:SEG_W-1] SEG7_HEX_7 = 7'b0001111;
  localparam logic [0:SEG_W-1] SEG7_HEX_8 = 7'b0000000;
  localparam logic [0:SEG_W-1] SEG7_HEX_9 = 7'b0000100;
  localparam logic [0:SEG_W-1] SEG7_HEX_A = 7'b0001000;
  localparam logic [0:SEG_W-1] SEG7_HEX_B = 7'b1100000;
  localparam logic [0:SEG_W-1] SEG7_HEX_C = 7'b0110001;
  localparam logic [0:SEG_W-1] SEG7_HEX_D = 7'b1000010;
  localparam logic [0:SEG_W-1] SEG7_HEX_E = 7'b0110000;
  localparam logic [0:SEG_W-1] SEG7_HEX_F = 7'b0111000;

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT} cap_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Reverse map of an active-low 7-segment pattern to its hex nibble; purely combinational, no flow control.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [0:SEG_W-1] i_seg,
  output logic             o_hit,
  output logic [3:0]       o_nibble
);

  always_comb begin
    o_hit    = 1'b1;
    o_nibble = 4'h0;
    case (i_seg)
      SEG7_HEX_0: o_nibble = 4'h0;
      SEG7_HEX_1: o_nibble = 4'h1;
      SEG7_HEX_2: o_nibble = 4'h2;
      SEG7_HEX_3: o_nibble = 4'h3;
      SEG7_HEX_4: o_nibble = 4'h4;
      SEG7_HEX_5: o_nibble = 4'h5;
      SEG7_HEX_6: o_nibble = 4'h6;
      SEG7_HEX_7: o_nibble = 4'h7;
      SEG7_HEX_8: o_nibble = 4'h8;
      SEG7_HEX_9: o_nibble = 4'h9;
      SEG7_HEX_A: o_nibble = 4'hA;
      SEG7_HEX_B: o_nibble = 4'hB;
      SEG7_HEX_C: o_nibble = 4'hC;
      SEG7_HEX_D: o_nibble = 4'hD;
      SEG7_HEX_E: o_nibble = 4'hE;
      SEG7_HEX_F: o_nibble = 4'hF;
      default:    o_hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Debounced capture of a multiplexed 7-segment bus into per-digit nibbles; outputs update one cycle after the qualifying sample.
// No backpressure: input is only looked at under sample_en. SEG7_CAP_DP_EN adds decimal-point capture (dp_in/dp_out).
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 8,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [0:SEG_W-1]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_CAP_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pattern
);

`ifdef SEG7_CAP_DP_EN
  localparam int SMP_W = NUM_DIGITS + SEG_W + 1;
`else
  localparam int SMP_W = NUM_DIGITS + SEG_W;
`endif

  cap_state_t              r_state;
  logic [SMP_W-1:0]        r_sample;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_frame_done;
  logic                    r_err;

  logic [SMP_W-1:0]        w_sample;
  logic                    w_match;
  logic                    w_qualify;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [0:SEG_W-1]        w_seg;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_hit;
  logic [3:0]              w_nibble;
  logic                    w_blank;
  logic                    w_good;
  logic                    w_bad;

`ifdef SEG7_CAP_DP_EN
  logic [NUM_DIGITS-1:0]   r_dp;
  assign w_sample = {dig_sel, seg_in, dp_in};
  assign dp_out   = r_dp;
`else
  assign w_sample = {dig_sel, seg_in};
`endif

  assign w_match   = (w_sample == r_sample);
  assign w_qualify = sample_en && w_match && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (sample_en) begin
      if (!w_match)
        w_cnt_nxt = CNT_W'(1);
      else if (r_cnt != CNT_W'(STABLE_CYCLES))
        w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Commit decodes the stored sample, since COMMIT may already be overwriting r_sample.
  assign w_sel = ~r_sample[SMP_W-1 -: NUM_DIGITS];
  assign w_seg = r_sample[SMP_W-NUM_DIGITS-1 -: SEG_W];

  seg7_pattern_lookup u_lookup (
    .i_seg    (w_seg),
    .o_hit    (w_hit),
    .o_nibble (w_nibble)
  );

  assign w_blank = (w_sel == '0);
  assign w_good  = $onehot(w_sel) && w_hit;
  assign w_bad   = !w_blank && !w_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sample     <= '0;
      r_cnt        <= '0;
      r_digits     <= '0;
      r_valid      <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
`ifdef SEG7_CAP_DP_EN
      r_dp         <= '0;
`endif
    end else begin
      if (sample_en)
        r_sample <= w_sample;
      r_cnt <= w_cnt_nxt;

      case (r_state)
        IDLE:    if (sample_en) r_state <= TRACK;
        TRACK:   if (w_qualify) r_state <= COMMIT;
        COMMIT:  r_state <= TRACK;
        default: r_state <= IDLE;
      endcase

      r_frame_done <= &r_valid;
      if (&r_valid)
        r_valid <= '0;

      if (r_state == COMMIT) begin
        if (w_good) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
              r_digits[4*i +: 4] <= w_nibble;
              r_valid[i]         <= 1'b1;
`ifdef SEG7_CAP_DP_EN
              r_dp[i]            <= ~r_sample[0];
`endif
            end
          end
        end
        if (w_bad)
          r_err <= 1'b1;
      end
    end
  end

  assign digits_out  = r_digits;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign err_pattern = r_err;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized and directed bench for seg7_scan_capture against a run-length reference model.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int S  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [0:6]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          err_pattern;
`ifdef SEG7_CAP_DP_EN
  logic          dp_in = 1'b1;
  logic [ND-1:0] dp_out;
`endif

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
`ifdef SEG7_CAP_DP_EN
    .dp_in       (dp_in),
    .dp_out      (dp_out),
`endif
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  bit [6:0] tbl [16];

  // reference model state
  bit [10:0]   m_last;
  int          m_run;
  bit          m_pend;
  bit [10:0]   m_psamp;
  bit [4*ND-1:0] m_digits;
  bit [ND-1:0] m_valid;
  bit          m_fd;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_commit(input bit [10:0] smp, inout bit [ND-1:0] nv);
    bit [3:0] d;
    int lows, idx, hex;
    d = smp[10:7];
    lows = 0; idx = -1; hex = -1;
    for (int i = 0; i < ND; i++)
      if (!d[i]) begin lows++; idx = i; end
    for (int k = 0; k < 16; k++)
      if (tbl[k] == smp[6:0]) hex = k;
    if (lows == 0) return;
    if (lows == 1 && hex >= 0) begin
      m_digits[4*idx +: 4] = 4'(hex);
      nv[idx] = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_step();
    bit [ND-1:0] nv;
    bit [10:0] cur;
    if (rst) begin
      m_last = '0; m_run = 0; m_pend = 0; m_psamp = '0;
      m_digits = '0; m_valid = '0; m_fd = 0; m_err = 0;
      return;
    end
    nv = m_valid;
    m_fd = (m_valid == '1);
    if (m_fd) nv = '0;
    if (m_pend) begin
      model_commit(m_psamp, nv);
      m_pend = 0;
    end
    m_valid = nv;
    if (sample_en) begin
      cur = {dig_sel, seg_in};
      if (cur == m_last) begin
        if (m_run == S - 1) begin
          m_pend = 1;
          m_psamp = cur;
        end
        if (m_run < S) m_run++;
      end else begin
        m_last = cur;
        m_run = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
    chk("digits_out", digits_out, m_digits);
    chk("digit_valid", digit_valid, m_valid);
    chk("frame_done", frame_done, m_fd);
    chk("err_pattern", err_pattern, m_err);
  endtask

  task automatic hold(input bit [3:0] d, input bit [6:0] s, input int n);
    sample_en = 1'b1; dig_sel = d; seg_in = s;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit [3:0] d;
    bit [6:0] s;
    int r, len;

    tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010; tbl[3]  = 7'b0000110;
    tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100; tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111;
    tbl[8]  = 7'b0000000; tbl[9]  = 7'b0000100; tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
    tbl[12] = 7'b0110001; tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;

    rst = 1'b1; sample_en = 1'b0; dig_sel = '1; seg_in = '1;
    tick(); tick();
    rst = 1'b0;
    idle(1);
    chk("reset_all_zero", {digits_out, digit_valid, frame_done, err_pattern}, 32'h0);

    // single stable run commits once
    hold(4'b1110, tbl[2], 8);
    chk("no_early_commit", digit_valid, 4'b0000);
    hold(4'b1110, tbl[2], 1);
    chk("d0_is_2", digits_out[3:0], 4'h2);
    chk("valid_0001", digit_valid, 4'b0001);
    hold(4'b1110, tbl[2], 4);

    // short run of one pattern, then full run of another
    hold(4'b1110, tbl[2], 7);
    hold(4'b1110, tbl[3], 9);
    chk("d0_is_3", digits_out[3:0], 4'h3);

    // full frame
    fd_cnt = 0;
    hold(4'b1110, tbl[1], 8);
    hold(4'b1101, tbl[11], 8);
    hold(4'b1011, tbl[12], 8);
    hold(4'b0111, tbl[15], 8);
    idle(4);
    chk("frame_pulses", fd_cnt, 1);
    chk("frame_valid_clr", digit_valid, 4'b0000);
    chk("frame_digits", digits_out, 16'hFCB1);

    // bad pattern and bad select
    hold(4'b1110, 7'b1111110, 9);
    chk("err_miss", err_pattern, 1'b1);
    chk("err_no_write", digits_out, 16'hFCB1);
    hold(4'b1100, tbl[5], 9);
    chk("err_sticky", err_pattern, 1'b1);
    chk("multi_no_write", digits_out, 16'hFCB1);

    // reset mid-run aborts the run
    do_reset();
    hold(4'b1110, tbl[7], 5);
    do_reset();
    hold(4'b1110, tbl[7], 3);
    idle(3);
    chk("abort_no_commit", digit_valid, 4'b0000);
    hold(4'b1110, tbl[7], 6);
    chk("fresh_run_commit", digits_out[3:0], 4'h7);

    // blank select never errors
    hold(4'b1111, 7'b1111110, 10);
    chk("blank_no_err", err_pattern, 1'b0);

    // randomized runs
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       d = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) d = 4'hF;
      else             d = 4'($urandom);
      if ($urandom_range(0, 9) < 8) s = tbl[$urandom_range(0, 15)];
      else                          s = 7'($urandom);
      dig_sel = d; seg_in = s;
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        sample_en = ($urandom_range(0, 3) != 0);
        tick();
      end
      if ($urandom_range(0, 59) == 0) do_reset();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
